// File: rtl/div_unit_pkg.sv
// Shared EX-stage definitions used by the divider: aluop codes for the
// divide family, the divider result-select code and the divider state encoding.
package div_unit_pkg;

  // aluop codes for the divide family, decoded in EX into signed_i/mod_i
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_MOD_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1100;
  localparam logic [7:0] EXE_MODU_OP = 8'b0001_1101;

  // EX result-select code that routes the divider output to the writeback bus
  localparam logic [2:0] EXE_RES_DIV = 3'b110;

  // Divider sequencer states
  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_BUSY    = 2'd1,
    DIV_DIVZERO = 2'd2,
    DIV_DONE    = 2'd3
  } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage. Handles signed and
// unsigned divide/modulo by dividing magnitudes and fixing the signs up on
// the way into DONE. Stalls the pipeline while iterating and holds the
// result in DONE for as long as EX is frozen by another stall source.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             mod_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] result_o
);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;     // partial remainder; original dividend in DIVZERO
  logic [WIDTH-1:0] r_quo;     // shifts dividend out while quotient bits shift in
  logic [WIDTH-1:0] r_div;     // divisor magnitude
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_mod;
  logic             r_ready;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic             w_last;

  // Operand magnitudes; only signed ops with a negative operand are negated
  always_comb begin
    w_a_mag = dividend_i;
    w_b_mag = divisor_i;
    if (signed_i && dividend_i[WIDTH-1]) begin
      w_a_mag = ~dividend_i + WIDTH'(1);
    end else begin
      w_a_mag = dividend_i;
    end
    if (signed_i && divisor_i[WIDTH-1]) begin
      w_b_mag = ~divisor_i + WIDTH'(1);
    end else begin
      w_b_mag = divisor_i;
    end
  end

  // One restoring step: shift {rem,quo} left, trial-subtract on WIDTH+1 bits.
  // When there is no borrow the true difference is below the divisor, so its
  // low WIDTH bits are exact.
  always_comb begin
    w_rem_sh    = {r_rem, r_quo[WIDTH-1]};
    w_no_borrow = (w_rem_sh >= {1'b0, r_div});
    w_diff      = w_rem_sh[WIDTH-1:0] - r_div;
    w_quo_nxt   = {r_quo[WIDTH-2:0], w_no_borrow};
    if (w_no_borrow) begin
      w_rem_nxt = w_diff;
    end else begin
      w_rem_nxt = w_rem_sh[WIDTH-1:0];
    end
  end

  // Sign fix-up applied to the final step's outputs as DONE is entered
  always_comb begin
    w_last = (r_cnt == CNT_W'(WIDTH - 1));
    if (r_q_neg) begin
      w_quo_fix = ~w_quo_nxt + WIDTH'(1);
    end else begin
      w_quo_fix = w_quo_nxt;
    end
    if (r_r_neg) begin
      w_rem_fix = ~w_rem_nxt + WIDTH'(1);
    end else begin
      w_rem_fix = w_rem_nxt;
    end
  end

  // Sequencer and datapath registers; flush beats start and hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_mod    <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else if (flush_i) begin
      r_state <= DIV_IDLE;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_ready <= 1'b0;
          if (start_i) begin
            r_mod <= mod_i;
            r_cnt <= '0;
            if (divisor_i == '0) begin
              // Quotient all-ones, remainder is the untouched dividend
              r_state <= DIV_DIVZERO;
              r_rem   <= dividend_i;
              r_quo   <= '1;
              r_div   <= '0;
              r_q_neg <= 1'b0;
              r_r_neg <= 1'b0;
            end else begin
              r_state <= DIV_BUSY;
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_div   <= w_b_mag;
              r_q_neg <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
              r_r_neg <= signed_i & dividend_i[WIDTH-1];
            end
          end else begin
            r_state <= DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state  <= DIV_DONE;
            r_rem    <= w_rem_fix;
            r_quo    <= w_quo_fix;
            r_ready  <= 1'b1;
            r_result <= r_mod ? w_rem_fix : w_quo_fix;
          end else begin
            r_state <= DIV_BUSY;
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
          end
        end
        DIV_DIVZERO: begin
          r_state  <= DIV_DONE;
          r_ready  <= 1'b1;
          r_result <= r_mod ? r_rem : r_quo;
        end
        DIV_DONE: begin
          // start_i is deliberately ignored here; EX moves on first
          if (hold_i) begin
            r_state <= DIV_DONE;
            r_ready <= 1'b1;
          end else begin
            r_state <= DIV_IDLE;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= DIV_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Stall request: low in DONE so EX advances with the result
  always_comb begin
    stall_o = 1'b0;
    if (flush_i) begin
      stall_o = 1'b0;
    end else begin
      stall_o = ((r_state == DIV_IDLE) && start_i) ||
                (r_state == DIV_BUSY) || (r_state == DIV_DIVZERO);
    end
  end

  assign ready_o  = r_ready;
  assign result_o = r_result;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: per-feature tasks with a scoreboard queue
// of expected results pushed when an op is driven and popped on ready_o.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        mod_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        flush_i;
  logic        hold_i;
  logic        stall_o;
  logic        ready_o;
  logic [31:0] result_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .mod_i      (mod_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .flush_i    (flush_i),
    .hold_i     (hold_i),
    .stall_o    (stall_o),
    .ready_o    (ready_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the instruction semantics
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sg, input logic md);
    int sa, sb;
    if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
    if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md ? 32'd0 : 32'h8000_0000;
      sa = int'(a);
      sb = int'(b);
      return md ? 32'(sa % sb) : 32'(sa / sb);
    end
    return md ? (a % b) : (a / b);
  endfunction

  // Drive one op (cycle 0 = start cycle), wait for ready_o, report result,
  // ready latency and number of cycles with stall_o high
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input logic md,
                       output logic [31:0] res, output int lat, output int stalls);
    res = 32'hDEAD_BEEF;
    lat = -1;
    stalls = 0;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = sg; mod_i = md; dividend_i = a; divisor_i = b;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (ready_o) begin
        lat = c;
        res = result_o;
        break;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; mod_i = 1'b0;
    dividend_i = 32'd0; divisor_i = 32'd0; flush_i = 1'b0; hold_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (ready_o !== 1'b0 || result_o !== 32'd0 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL reset: ready=%b result=%h stall=%b expected 0/0/0", ready_o, result_o, stall_o);
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] r, e;
    int lat, st;
    exp_q.push_back(32'd14);
    do_op(32'd100, 32'd7, 1'b0, 1'b0, r, lat, st);
    e = exp_q.pop_front();
    total++;
    if (r !== e || lat !== 33 || st !== 33) begin
      bad++;
      $display("FAIL udiv_100_7: result=%h lat=%0d stalls=%0d expected %h/33/33", r, lat, st, e);
    end
    exp_q.push_back(32'd2);
    do_op(32'd100, 32'd7, 1'b0, 1'b1, r, lat, st);
    e = exp_q.pop_front();
    total++;
    if (r !== e || lat !== 33 || st !== 33) begin
      bad++;
      $display("FAIL umod_100_7: result=%h lat=%0d stalls=%0d expected %h/33/33", r, lat, st, e);
    end
  endtask

  task automatic test_signed();
    logic [31:0] r, e;
    int lat, st;
    logic [31:0] exp_tab [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_tab[i]);
      do_op(32'hFFFF_FFF9, 32'd2, (i < 2) ? 1'b1 : 1'b0, i[0], r, lat, st);
      e = exp_q.pop_front();
      total++;
      if (r !== e || lat !== 33) begin
        bad++;
        $display("FAIL neg7_by_2[%0d]: result=%h lat=%0d expected %h/33", i, r, lat, e);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r, e;
    int lat, st;
    exp_q.push_back(32'h8000_0000);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, r, lat, st);
    e = exp_q.pop_front();
    total++;
    if (r !== e) begin
      bad++;
      $display("FAIL ovf_quo: result=%h expected %h", r, e);
    end
    exp_q.push_back(32'h0000_0000);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, r, lat, st);
    e = exp_q.pop_front();
    total++;
    if (r !== e) begin
      bad++;
      $display("FAIL ovf_rem: result=%h expected %h", r, e);
    end
  endtask

  task automatic test_divzero();
    logic [31:0] r, e;
    int lat, st;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i[0] ? 32'h1234_5678 : 32'hFFFF_FFFF);
      do_op(32'h1234_5678, 32'd0, i[1], i[0], r, lat, st);
      e = exp_q.pop_front();
      total++;
      if (r !== e || lat !== 2 || st !== 2) begin
        bad++;
        $display("FAIL divzero[%0d]: result=%h lat=%0d stalls=%0d expected %h/2/2", i, r, lat, st, e);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, r, e;
    int lat, st, seen;
    prev = result_o;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; mod_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall: stall=%b expected 0", stall_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle: stall=%b ready=%b expected 0/0", stall_o, ready_o);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready_o || result_o !== prev) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL flush_quiet: disturbed_cycles=%0d expected 0 (result=%h prev=%h)", seen, result_o, prev);
    end
    exp_q.push_back(32'd3);
    do_op(32'd9, 32'd3, 1'b0, 1'b0, r, lat, st);
    e = exp_q.pop_front();
    total++;
    if (r !== e || lat !== 33) begin
      bad++;
      $display("FAIL after_flush_9_3: result=%h lat=%0d expected %h/33", r, lat, e);
    end
  endtask

  // Flush on the exact start cycle must beat start_i
  task automatic test_flush_start();
    int seen;
    @(posedge clk); #1;
    start_i = 1'b1; flush_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (stall_o || ready_o) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL flush_beats_start: active_cycles=%0d expected 0", seen);
    end
  endtask

  task automatic test_hold();
    logic [31:0] e, first;
    int hcnt, lat;
    exp_q.push_back(32'd100);
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; mod_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd10;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ready_o) begin lat = c; break; end
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    e = exp_q.pop_front();
    first = result_o;
    total++;
    if (lat !== 33 || first !== e) begin
      bad++;
      $display("FAIL hold_first: lat=%0d result=%h expected 33/%h", lat, first, e);
    end
    hold_i = 1'b1;
    start_i = 1'b1;
    hcnt = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (hcnt == 3) hold_i = 1'b0;
      @(negedge clk);
      if (!ready_o) break;
      hcnt++;
      total++;
      if (result_o !== e || stall_o !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable: result=%h stall=%b expected %h/0", result_o, stall_o, e);
      end
    end
    total++;
    if (hcnt != 4) begin
      bad++;
      $display("FAIL hold_ready_cycles: got=%0d expected 4", hcnt);
    end
    // Now back in IDLE with start_i still high: stall must request
    total++;
    if (ready_o !== 1'b0 || stall_o !== 1'b1 || result_o !== e) begin
      bad++;
      $display("FAIL hold_release: ready=%b stall=%b result=%h expected 0/1/%h", ready_o, stall_o, result_o, e);
    end
    start_i = 1'b0;
    hold_i = 1'b0;
    #1;
    total++;
    if (stall_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_idle_stall: stall=%b expected 0", stall_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, r, e;
    logic sg, md;
    int lat, st;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'd1 : ($urandom >> $urandom_range(0, 28));
      if (b == 32'd0) b = 32'd13;
      sg = i[0];
      md = i[1];
      exp_q.push_back(model(a, b, sg, md));
      do_op(a, b, sg, md, r, lat, st);
      e = exp_q.pop_front();
      total++;
      if (r !== e || lat !== 33) begin
        bad++;
        $display("FAIL b2b[%0d] %h/%h s=%b m=%b: result=%h lat=%0d expected %h/33", i, a, b, sg, md, r, lat, e);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b1; mod_i = 1'b0; dividend_i = 32'd77; divisor_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ready_o !== 1'b0 || result_o !== 32'd0 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_op: ready=%b result=%h stall=%b expected 0/0/0", ready_o, result_o, stall_o);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_divzero();
    test_flush();
    test_flush_start();
    test_hold();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div_unit
